// File: rtl/kronos_mem_arbiter.sv
// Shares one memory port between kronos_core instruction fetch and load/store.
// Optional build macro KRONOS_ARB_RR_EN selects round-robin instead of data priority with fetch starvation guard.
module kronos_mem_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic [31:0] data_rd_data,
    output logic        data_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_mask,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_ack,
    output logic        grant_instr,
    output logic        grant_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   data_first_s;

    // data_first breaks the tie when both requesters are pending
    function automatic state_t arb_fn(input logic ri, input logic rd, input logic data_first);
        state_t res;
        if (rd && (!ri || data_first)) begin
            res = GNT_D;
        end else if (ri) begin
            res = GNT_I;
        end else begin
            res = IDLE;
        end
        return res;
    endfunction

`ifdef KRONOS_ARB_RR_EN
    logic prio_r;

    assign data_first_s = prio_r;

    // round-robin pointer: after an ack the other requester is preferred
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r <= 1'b1;
        end else if (data_ack) begin
            prio_r <= 1'b0;
        end else if (instr_ack) begin
            prio_r <= 1'b1;
        end else begin
            prio_r <= prio_r;
        end
    end
`else
    logic [CNT_W-1:0] wait_cnt_r;
    logic             starve_s;

    assign starve_s     = (wait_cnt_r == CNT_W'(MAX_WAIT));
    assign data_first_s = !starve_s;

    // counts data grants completed while a fetch waits; saturates at MAX_WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (instr_ack || ((state_r == IDLE) && !instr_req)) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (data_ack && instr_req && !starve_s) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`endif

    // grant state register; the only place a grant is remembered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // next grant: arbitrate in IDLE, hand over on ack, release on withdrawal
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                state_s = arb_fn(instr_req, data_req, data_first_s);
            end
            GNT_I: begin
                if (mem_ack) begin
                    state_s = arb_fn(1'b0, data_req, data_first_s);
                end else if (!instr_req) begin
                    state_s = IDLE;
                end else begin
                    state_s = GNT_I;
                end
            end
            GNT_D: begin
                if (mem_ack) begin
                    state_s = arb_fn(instr_req, 1'b0, data_first_s);
                end else if (!data_req) begin
                    state_s = IDLE;
                end else begin
                    state_s = GNT_D;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign grant_instr = (state_r == GNT_I);
    assign grant_data  = (state_r == GNT_D);

    // memory-side mux; fetches are always full-word reads
    always_comb begin
        mem_req     = 1'b0;
        mem_addr    = 32'h0000_0000;
        mem_wr_data = 32'h0000_0000;
        mem_mask    = 4'h0;
        mem_wr_en   = 1'b0;
        case (state_r)
            GNT_I: begin
                mem_req     = instr_req;
                mem_addr    = instr_addr;
                mem_wr_data = 32'h0000_0000;
                mem_mask    = 4'hF;
                mem_wr_en   = 1'b0;
            end
            GNT_D: begin
                mem_req     = data_req;
                mem_addr    = data_addr;
                mem_wr_data = data_wr_data;
                mem_mask    = data_mask;
                mem_wr_en   = data_wr_en;
            end
            default: begin
                mem_req     = 1'b0;
                mem_addr    = 32'h0000_0000;
                mem_wr_data = 32'h0000_0000;
                mem_mask    = 4'h0;
                mem_wr_en   = 1'b0;
            end
        endcase
    end

    // acks follow mem_ack in the same cycle; an ack in IDLE goes nowhere
    always_comb begin
        instr_ack    = mem_ack & grant_instr;
        data_ack     = mem_ack & grant_data;
        instr_data   = 32'h0000_0000;
        data_rd_data = 32'h0000_0000;
        if (instr_ack) begin
            instr_data = mem_rd_data;
        end else begin
            instr_data = 32'h0000_0000;
        end
        if (data_ack) begin
            data_rd_data = mem_rd_data;
        end else begin
            data_rd_data = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Directed self-checking bench for kronos_mem_arbiter (default build; RR checks under KRONOS_ARB_RR_EN).
module tb_kronos_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data;
    logic        instr_ack;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic [31:0] data_rd_data;
    logic        data_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_mask;
    logic        mem_wr_en;
    logic        mem_req;
    logic [31:0] mem_rd_data;
    logic        mem_ack;
    logic        grant_instr;
    logic        grant_data;

    int total_cnt;
    int bad_cnt;

    kronos_mem_arbiter #(.MAX_WAIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_addr   (instr_addr),
        .instr_req    (instr_req),
        .instr_data   (instr_data),
        .instr_ack    (instr_ack),
        .data_addr    (data_addr),
        .data_wr_data (data_wr_data),
        .data_mask    (data_mask),
        .data_wr_en   (data_wr_en),
        .data_req     (data_req),
        .data_rd_data (data_rd_data),
        .data_ack     (data_ack),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_mask     (mem_mask),
        .mem_wr_en    (mem_wr_en),
        .mem_req      (mem_req),
        .mem_rd_data  (mem_rd_data),
        .mem_ack      (mem_ack),
        .grant_instr  (grant_instr),
        .grant_data   (grant_data)
    );

    // free-running core clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // inputs change 1 time unit after the edge; checks happen 1 unit later still
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // directed stimulus
    initial begin
        total_cnt    = 0;
        bad_cnt      = 0;
        clk          = 1'b0;
        rst          = 1'b1;
        instr_addr   = 32'h0000_0100;
        instr_req    = 1'b1;
        data_addr    = 32'h0000_4000;
        data_wr_data = 32'h1234_5678;
        data_mask    = 4'hF;
        data_wr_en   = 1'b0;
        data_req     = 1'b1;
        mem_rd_data  = 32'h0000_0000;
        mem_ack      = 1'b0;

        // reset held with both requests pending
        step();
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_acks", {30'd0, instr_ack, data_ack}, 32'd0);
        check_eq("rst_grants", {30'd0, grant_instr, grant_data}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0000_0000);
        rst = 1'b0;
        step();
        check_eq("post_rst_gnt_d", {31'd0, grant_data}, 32'd1);
        check_eq("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
        check_eq("post_rst_addr", mem_addr, 32'h0000_4000);

        // reset during a grant with an ack in flight
        rst     = 1'b1;
        mem_ack = 1'b1;
        step();
        check_eq("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("midrst_gnt", {30'd0, grant_instr, grant_data}, 32'd0);
        check_eq("midrst_ack_drop", {30'd0, instr_ack, data_ack}, 32'd0);
        rst       = 1'b0;
        mem_ack   = 1'b0;
        instr_req = 1'b0;
        data_req  = 1'b0;
        step();

        // fetch only, memory acks on the second granted cycle
        instr_req    = 1'b1;
        data_wr_en   = 1'b1;
        data_wr_data = 32'hDEAD_BEEF;
        settle();
        check_eq("if_idle_latency", {31'd0, mem_req}, 32'd0);
        step();
        check_eq("if_gnt", {31'd0, grant_instr}, 32'd1);
        check_eq("if_addr", mem_addr, 32'h0000_0100);
        check_eq("if_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check_eq("if_mask", {28'd0, mem_mask}, 32'h0000_000F);
        check_eq("if_wr_data", mem_wr_data, 32'h0000_0000);
        check_eq("if_no_ack", {31'd0, instr_ack}, 32'd0);
        step();
        check_eq("if_wr_en_w", {31'd0, mem_wr_en}, 32'd0);
        mem_ack     = 1'b1;
        mem_rd_data = 32'h0000_0013;
        settle();
        check_eq("if_ack", {31'd0, instr_ack}, 32'd1);
        check_eq("if_data", instr_data, 32'h0000_0013);
        check_eq("if_d_ack", {31'd0, data_ack}, 32'd0);
        check_eq("if_d_rdata", data_rd_data, 32'h0000_0000);
        step();
        instr_req = 1'b0;
        mem_ack   = 1'b0;
        settle();
        check_eq("if_ack_pulse", {31'd0, instr_ack}, 32'd0);
        check_eq("if_data_qual", instr_data, 32'h0000_0000);
        check_eq("if_back_idle", {30'd0, grant_instr, grant_data}, 32'd0);

        // contention: store to 0x2000 wins, fetch follows with no bubble
        instr_req    = 1'b1;
        instr_addr   = 32'h0000_0104;
        data_req     = 1'b1;
        data_addr    = 32'h0000_2000;
        data_wr_data = 32'hCAFE_BABE;
        data_mask    = 4'b0011;
        data_wr_en   = 1'b1;
        step();
        check_eq("ct_gnt_d", {31'd0, grant_data}, 32'd1);
        check_eq("ct_addr", mem_addr, 32'h0000_2000);
        check_eq("ct_mask", {28'd0, mem_mask}, 32'h0000_0003);
        check_eq("ct_wr_en", {31'd0, mem_wr_en}, 32'd1);
        check_eq("ct_wr_data", mem_wr_data, 32'hCAFE_BABE);
        mem_ack = 1'b1;
        settle();
        check_eq("ct_d_ack", {31'd0, data_ack}, 32'd1);
        step();
        data_req   = 1'b0;
        data_wr_en = 1'b0;
        mem_ack    = 1'b0;
        settle();
        check_eq("ct_handover", {30'd0, grant_instr, grant_data}, 32'h0000_0002);
        check_eq("ct_i_addr", mem_addr, 32'h0000_0104);
        check_eq("ct_i_req", {31'd0, mem_req}, 32'd1);
        mem_ack     = 1'b1;
        mem_rd_data = 32'h0000_0093;
        settle();
        check_eq("ct_i_data", instr_data, 32'h0000_0093);
        step();
        instr_req = 1'b0;
        mem_ack   = 1'b0;

        // abort: fetch withdrawn before ack, waiting load granted two cycles later
        instr_req = 1'b1;
        step();
        instr_req = 1'b0;
        data_req  = 1'b1;
        data_addr = 32'h0000_3000;
        settle();
        check_eq("ab_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("ab_still_i", {31'd0, grant_instr}, 32'd1);
        step();
        check_eq("ab_idle", {30'd0, grant_instr, grant_data}, 32'd0);
        check_eq("ab_idle_req", {31'd0, mem_req}, 32'd0);
        step();
        check_eq("ab_gnt_d", {31'd0, grant_data}, 32'd1);
        check_eq("ab_d_addr", mem_addr, 32'h0000_3000);
        mem_ack     = 1'b1;
        mem_rd_data = 32'h0000_55AA;
        settle();
        check_eq("ab_d_ack", {31'd0, data_ack}, 32'd1);
        check_eq("ab_d_rdata", data_rd_data, 32'h0000_55AA);
        check_eq("ab_i_data", instr_data, 32'h0000_0000);
        step();
        data_req = 1'b0;
        mem_ack  = 1'b0;
        step();

`ifndef KRONOS_ARB_RR_EN
        // starvation: each fetch grant is withdrawn so data keeps winning until the guard trips
        for (int k = 0; k < 8; k++) begin
            instr_req = 1'b1;
            data_req  = 1'b1;
            step();
            check_eq($sformatf("sv_gnt_d_%0d", k), {31'd0, grant_data}, 32'd1);
            mem_ack = 1'b1;
            step();
            mem_ack   = 1'b0;
            instr_req = 1'b0;
            step();
        end
        instr_req = 1'b1;
        step();
        check_eq("sv_guard_i", {30'd0, grant_instr, grant_data}, 32'h0000_0002);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        settle();
        check_eq("sv_after_i", {31'd0, grant_data}, 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack   = 1'b0;
        instr_req = 1'b0;
        step();
        instr_req = 1'b1;
        step();
        check_eq("sv_cnt_clr", {31'd0, grant_data}, 32'd1);
        instr_req = 1'b0;
        data_req  = 1'b0;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
`else
        // round-robin: alternation under constant contention, then pointer decides a tie in IDLE
        rst       = 1'b1;
        instr_req = 1'b1;
        data_req  = 1'b1;
        step();
        rst = 1'b0;
        step();
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rr_gnt_d_%0d", i), {31'd0, grant_data}, {31'd0, (i % 2 == 0)});
            check_eq($sformatf("rr_gnt_i_%0d", i), {31'd0, grant_instr}, {31'd0, (i % 2 == 1)});
            step();
        end
        instr_req = 1'b0;
        step();
        mem_ack   = 1'b0;
        instr_req = 1'b1;
        step();
        check_eq("rr_ptr_i", {30'd0, grant_instr, grant_data}, 32'h0000_0002);
        instr_req = 1'b0;
        data_req  = 1'b0;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/kronos_mem_arbiter.md
Name: kronos_mem_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch interface and its load/store interface.
- Sits between kronos_core and a single-ported memory or bus bridge.
- Grants one requester per transaction and holds the grant until that requester's access is acknowledged.
- Default policy is data-over-instruction priority with a starvation guard for fetch.

Parameters:
- MAX_WAIT, 8: maximum number of consecutive data grants while a fetch is pending. When reached, fetch wins the next arbitration.
- CNT_W, $clog2(MAX_WAIT+1): width of the starvation counter. Derived; do not override.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- instr_addr  in  32  fetch address.
- instr_req  in  1  fetch request; held high until instr_ack.
- instr_data  out  32  fetch read data.
- instr_ack  out  1  fetch acknowledge, one-cycle pulse.
- data_addr  in  32  load/store address.
- data_wr_data  in  32  store data.
- data_mask  in  4  byte enables.
- data_wr_en  in  1  1 = store, 0 = load.
- data_req  in  1  load/store request; held high until data_ack.
- data_rd_data  out  32  load data.
- data_ack  out  1  load/store acknowledge, one-cycle pulse.
- mem_addr  out  32  shared port address.
- mem_wr_data  out  32  shared port store data.
- mem_mask  out  4  shared port byte enables.
- mem_wr_en  out  1  shared port write enable.
- mem_req  out  1  shared port request.
- mem_rd_data  in  32  shared port read data.
- mem_ack  in  1  shared port acknowledge.
- grant_instr  out  1  state is GNT_I (status/debug).
- grant_data  out  1  state is GNT_D (status/debug).

Behaviour:
- Reset: one clock, rst, synchronous and active-high.
  - State goes to IDLE and wait_cnt to 0. Priority pointer resets to data (RR build only).
  - All outputs read 0 in the cycle after rst is sampled high.
  - Reset mid-transaction drops mem_req and returns to IDLE. Any in-flight mem_ack is ignored.
- States: IDLE, GNT_I, GNT_D. The state register is the only grant storage.
- Arbitration function arb(ri, rd):
  - rd & !(ri & wait_cnt==MAX_WAIT) -> GNT_D.
  - else ri -> GNT_I.
  - else IDLE.
- IDLE: next state = arb(instr_req, data_req). mem_req = 0. One cycle of arbitration latency: a request sampled in IDLE produces mem_req on the next cycle.
- GNT_X:
  - mem_req = X_req (combinational).
  - mem_addr / mem_wr_data / mem_mask / mem_wr_en are muxed from requester X.
  - Instruction grant forces mem_wr_en=0, mem_mask=4'hF, mem_wr_data=0.
- In IDLE, mux outputs are 0.
- Ack routing:
  - X_ack = mem_ack & (state==GNT_X), combinational, same cycle.
  - instr_data and data_rd_data both equal mem_rd_data, qualified only by their ack.
  - mem_ack in IDLE is dropped.
- On acknowledged cycle in GNT_X: back-to-back handover. Next state = arb with X's request masked to 0, so only the other requester is considered; IDLE if it is not pending. No bubble.
- Abort: in GNT_X with X_req=0 and no mem_ack, next state = IDLE. The memory side tolerates request withdrawal, e.g. on a pipeline flush.
- Starvation counter wait_cnt:
  - Increments (saturating at MAX_WAIT) on each data_ack while instr_req=1.
  - Clears on instr_ack, or when instr_req=0 in IDLE.
- Simultaneous requests in IDLE: data wins unless wait_cnt==MAX_WAIT.
- mem_req never asserts for two requesters at once. Grant changes only in IDLE, on an ack cycle, or on abort.

Optional Feature:
- Macro: KRONOS_ARB_RR_EN.
- Defined: arbitration is round-robin.
  - A 1-bit pointer flips to the other requester on every ack.
  - When both requesters are pending, the one indicated by the pointer wins.
  - wait_cnt and MAX_WAIT are unused. Tie wait_cnt to 0.
- Undefined: fixed data priority with the starvation guard described above.

Test Plan:
- Reset: hold rst=1 with instr_req=data_req=1 -> mem_req=0, acks=0, grant_*=0. One cycle after rst drops -> grant_data=1, mem_req=1, mem_addr=data_addr.
- Instr only: instr_req=1, instr_addr=0x100, memory acks after 2 cycles with rd_data=0x00000013 -> instr_ack pulses once with instr_data=0x13, mem_wr_en=0 throughout.
- Contention: both requests high in IDLE, store to 0x2000 with mask 4'b0011 -> data granted first. On data_ack, grant_instr=1 on the next cycle with no IDLE bubble.
- Starvation: data_req held high continuously with instr_req=1, MAX_WAIT=8 -> after 8 data_acks, the next grant is instr. wait_cnt clears on instr_ack.
- Abort: in GNT_I, drop instr_req before mem_ack -> mem_req=0 same cycle, IDLE next cycle, pending data_req granted the cycle after.
- RR build (KRONOS_ARB_RR_EN): both requesters always pending, single-cycle acks -> grants alternate D, I, D, I.
